// File: rtl/w0rm_core_branch_unit_v2_if.sv
// Issue/result bus between the W0RM core and its branch resolution unit.
// master: the core side (drives the op, consumes the redirect/link results).
// slave : the branch unit.
interface w0rm_core_branch_unit_v2_if #(
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Issue side
  logic                  branch_ready;
  logic                  data_valid;
  logic                  is_branch;
  logic [3:0]            cond_code;
  logic                  is_link;
  logic                  branch_rel_abs;
  logic                  alu_flag_zero;
  logic                  alu_flag_negative;
  logic                  alu_flag_carry;
  logic                  alu_flag_overflow;
  logic [ADDR_WIDTH-1:0] branch_base_addr;
  logic [DATA_WIDTH-1:0] rn;
  logic [DATA_WIDTH-1:0] lit;
  logic                  pred_taken;
  logic [USER_WIDTH-1:0] user_data_in;

  // Result side
  logic                  branch_valid;
  logic                  link_valid;
  logic [DATA_WIDTH-1:0] next_link_reg;
  logic                  next_pc_valid;
  logic                  flush_pipeline;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [USER_WIDTH-1:0] user_data_out;

  modport master (
    output data_valid, is_branch, cond_code, is_link, branch_rel_abs,
           alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow,
           branch_base_addr, rn, lit, pred_taken, user_data_in,
    input  branch_ready, branch_valid, link_valid, next_link_reg,
           next_pc_valid, flush_pipeline, next_pc, user_data_out
  );

  modport slave (
    input  data_valid, is_branch, cond_code, is_link, branch_rel_abs,
           alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow,
           branch_base_addr, rn, lit, pred_taken, user_data_in,
    output branch_ready, branch_valid, link_valid, next_link_reg,
           next_pc_valid, flush_pipeline, next_pc, user_data_out
  );
endinterface

// File: rtl/w0rm_core_branch_unit_v2.sv
// W0RM core branch unit: two-stage branch resolution.
// S1 latches an accepted branch op; S2 resolves the condition, computes the
// target/link values and registers the fetch redirect. mem_ready=0 freezes
// both stages. Optional feature macro: BRANCH_PRED_EN (2-bit counter
// predictor; redirect only on mispredict).
module w0rm_core_branch_unit_v2 #(
  parameter int USER_WIDTH  = 1,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_BYTES = 2,
  parameter int PRED_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_ready,
  w0rm_core_branch_unit_v2_if.slave     bus,
  input  logic [ADDR_WIDTH-1:0]         fetch_pc,
  output logic                          fetch_pred_taken
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic                  valid;
    logic [3:0]            cond;
    logic                  link;
    logic                  abs;
    logic                  z;
    logic                  n;
    logic                  c;
    logic                  v;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] rn;
    logic [DATA_WIDTH-1:0] lit;
    logic                  pred;
    logic [USER_WIDTH-1:0] user;
  } op_t;

  op_t                   s1_q;
  op_t                   s1_d;
  logic                  flush;
  logic                  accept;
  logic                  resolve_en;
  logic                  taken;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] fall_through;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  unused_ok;

  // A registered redirect is the flush; the op sitting in S1 during it is stale.
  assign flush              = bus.next_pc_valid;
  assign bus.flush_pipeline = bus.next_pc_valid;
  assign bus.branch_ready   = mem_ready & ~flush;
  assign accept             = bus.data_valid & bus.is_branch & bus.branch_ready;
  assign resolve_en         = mem_ready & s1_q.valid & ~flush;

  // Pack the incoming op for the S1 register.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first, so no path leaves a variable unassigned and no latch is inferred.
    s1_d       = '0;
    s1_d.valid = 1'b1;
    s1_d.cond  = bus.cond_code;
    s1_d.link  = bus.is_link;
    s1_d.abs   = bus.branch_rel_abs;
    s1_d.z     = bus.alu_flag_zero;
    s1_d.n     = bus.alu_flag_negative;
    s1_d.c     = bus.alu_flag_carry;
    s1_d.v     = bus.alu_flag_overflow;
    s1_d.base  = bus.branch_base_addr;
    s1_d.rn    = bus.rn;
    s1_d.lit   = bus.lit;
    s1_d.pred  = bus.pred_taken;
    s1_d.user  = bus.user_data_in;
  end

  // Evaluate the condition code against the flags captured with the op.
  always_comb begin
    taken = 1'b0;
    case (s1_q.cond)
      4'h0: taken = s1_q.z;
      4'h1: taken = ~s1_q.z;
      4'h2: taken = s1_q.c;
      4'h3: taken = ~s1_q.c;
      4'h4: taken = s1_q.n;
      4'h5: taken = ~s1_q.n;
      4'h6: taken = s1_q.v;
      4'h7: taken = ~s1_q.v;
      4'h8: taken = s1_q.c & ~s1_q.z;
      4'h9: taken = ~s1_q.c | s1_q.z;
      4'hA: taken = (s1_q.n == s1_q.v);
      4'hB: taken = (s1_q.n != s1_q.v);
      4'hC: taken = ~s1_q.z & (s1_q.n == s1_q.v);
      4'hD: taken = s1_q.z | (s1_q.n != s1_q.v);
      4'hE: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Targets wrap modulo 2^ADDR_WIDTH; operands are resized to the PC width.
  assign fall_through = s1_q.base + STEP;
  assign target       = s1_q.abs ? ADDR_WIDTH'(s1_q.rn)
                                 : s1_q.base + ADDR_WIDTH'(s1_q.lit) + STEP;

`ifdef BRANCH_PRED_EN
  localparam int IDX_W   = $clog2(PRED_DEPTH);
  localparam int IDX_LSB = $clog2(INSTR_BYTES);

  logic [1:0]       pred_ctr [PRED_DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;

  assign fetch_idx        = fetch_pc[IDX_LSB +: IDX_W];
  assign upd_idx          = s1_q.base[IDX_LSB +: IDX_W];
  // Lookup reads the array before the resolve edge writes it: old value wins.
  assign fetch_pred_taken = pred_ctr[fetch_idx][1];

  // Redirect only when the resolved direction disagrees with the prediction.
  assign redirect    = taken ^ s1_q.pred;
  assign redirect_pc = taken ? target : fall_through;

  // Saturating counter training at resolve time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the counter table is small and must start weakly not-taken, so it
      // is reset in full here; larger data memories are normally left unreset.
      for (int i = 0; i < PRED_DEPTH; i++) pred_ctr[i] <= 2'b01;
    end else if (resolve_en) begin
      if (taken && pred_ctr[upd_idx] != 2'b11)
        pred_ctr[upd_idx] <= pred_ctr[upd_idx] + 2'd1;
      else if (!taken && pred_ctr[upd_idx] != 2'b00)
        pred_ctr[upd_idx] <= pred_ctr[upd_idx] - 2'd1;
    end
  end
`else
  // No predictor: every taken branch redirects, not-taken never does.
  assign fetch_pred_taken = 1'b0;
  assign redirect         = taken;
  assign redirect_pc      = target;
`endif

  // Inputs that only the predictor build consumes.
  assign unused_ok = ^{fetch_pc, s1_q.pred, 1'(PRED_DEPTH)};

  // S1 capture and S2 result registers; both freeze while mem_ready is low.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on clk) and all state uses
    // non-blocking '<=' so every register sees pre-edge values.
    if (!rst_n) begin
      s1_q              <= '0;
      bus.branch_valid  <= 1'b0;
      bus.link_valid    <= 1'b0;
      bus.next_link_reg <= '0;
      bus.next_pc_valid <= 1'b0;
      bus.next_pc       <= '0;
      bus.user_data_out <= '0;
    end else if (mem_ready) begin
      s1_q <= accept ? s1_d : '0;
      if (resolve_en) begin
        bus.branch_valid  <= taken;
        bus.link_valid    <= taken & s1_q.link;
        bus.next_link_reg <= (taken & s1_q.link) ? DATA_WIDTH'(fall_through) : '0;
        bus.next_pc_valid <= redirect;
        bus.next_pc       <= redirect ? redirect_pc : '0;
        bus.user_data_out <= taken ? s1_q.user : '0;
      end else begin
        bus.branch_valid  <= 1'b0;
        bus.link_valid    <= 1'b0;
        bus.next_link_reg <= '0;
        bus.next_pc_valid <= 1'b0;
        bus.next_pc       <= '0;
        bus.user_data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_w0rm_core_branch_unit_v2.sv
// Self-checking bench for w0rm_core_branch_unit_v2 (builds with or without
// BRANCH_PRED_EN). Driver issues ops and pushes expected responses into a
// queue; an independent monitor pops and compares whenever a pulse is shown.
module tb_w0rm_core_branch_unit_v2;
  localparam int UW = 1;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IB = 2;
  localparam int PD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] fetch_pc = '0;
  logic          fetch_pred_taken;

  always #5 clk = ~clk;

  w0rm_core_branch_unit_v2_if #(.USER_WIDTH(UW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  w0rm_core_branch_unit_v2 #(
    .USER_WIDTH(UW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .INSTR_BYTES(IB), .PRED_DEPTH(PD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_ready(mem_ready),
    .bus(bus),
    .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken)
  );

  typedef struct {
    logic          valid;
    logic          is_branch;
    logic [3:0]    cc;
    logic          link;
    logic          abs;
    logic          z, n, c, v;
    logic [AW-1:0] base;
    logic [DW-1:0] rn;
    logic [DW-1:0] lit;
    logic          pred;
    logic [UW-1:0] user;
  } op_t;

  typedef struct {
    logic          bv;
    logic          lv;
    logic [DW-1:0] lreg;
    logic          pv;
    logic [AW-1:0] pc;
    logic [UW-1:0] user;
  } resp_t;

  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;

  // Reference state: the op waiting to resolve, whether a redirect is showing,
  // and the predictor counters.
  bit    m_inflight = 1'b0;
  op_t   m_op;
  bit    m_redirect = 1'b0;
  int    m_ctr[PD];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] cc, input bit z, n, c, v);
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic resp_t model(input op_t op);
    resp_t r;
    bit t;
    logic [AW-1:0] tgt, fall;
    t    = cond_true(op.cc, op.z, op.n, op.c, op.v);
    fall = AW'(64'(op.base) + 64'(IB));
    tgt  = op.abs ? AW'(op.rn) : AW'(64'(op.base) + 64'(op.lit) + 64'(IB));
    r.bv   = t;
    r.lv   = t && op.link;
    r.lreg = r.lv ? DW'(fall) : '0;
`ifdef BRANCH_PRED_EN
    r.pv = (t != op.pred);
    r.pc = r.pv ? (t ? tgt : fall) : '0;
`else
    r.pv = t;
    r.pc = t ? tgt : '0;
`endif
    r.user = t ? op.user : '0;
    return r;
  endfunction

  function automatic int pidx(input logic [AW-1:0] pc);
    return int'((pc / AW'(IB)) % AW'(PD));
  endfunction

  function automatic op_t mk(input logic [3:0] cc, input logic abs, input logic link,
                             input logic [AW-1:0] base, input logic [DW-1:0] rn,
                             input logic [DW-1:0] lit, input logic [3:0] zncv);
    op_t o;
    o.valid = 1'b1; o.is_branch = 1'b1; o.cc = cc; o.abs = abs; o.link = link;
    o.z = zncv[3]; o.n = zncv[2]; o.c = zncv[1]; o.v = zncv[0];
    o.base = base; o.rn = rn; o.lit = lit; o.pred = 1'b0; o.user = 1'b1;
    return o;
  endfunction

  function automatic op_t idle_op();
    op_t o;
    o = mk(4'hE, 1'b0, 1'b0, '0, '0, '0, 4'h0);
    o.valid = 1'b0;
    o.user  = 1'b0;
    return o;
  endfunction

  // One clock: drive inputs, check ready/prediction, advance the reference.
  task automatic step(input op_t op, input bit mr, input bit rst, input logic [AW-1:0] fpc);
    bit    acc, nr, t;
    resp_t r;
    int    idx;
    mem_ready = mr; rst_n = rst; fetch_pc = fpc;
    bus.data_valid = op.valid; bus.is_branch = op.is_branch; bus.cond_code = op.cc;
    bus.is_link = op.link; bus.branch_rel_abs = op.abs;
    bus.alu_flag_zero = op.z; bus.alu_flag_negative = op.n;
    bus.alu_flag_carry = op.c; bus.alu_flag_overflow = op.v;
    bus.branch_base_addr = op.base; bus.rn = op.rn; bus.lit = op.lit;
    bus.pred_taken = op.pred; bus.user_data_in = op.user;
    @(negedge clk);
    if (mon_en) begin
      check("branch_ready", 128'(bus.branch_ready), 128'(mr && !m_redirect));
`ifdef BRANCH_PRED_EN
      check("fetch_pred_taken", 128'(fetch_pred_taken), 128'(m_ctr[pidx(fpc)] >= 2));
`else
      check("fetch_pred_taken", 128'(fetch_pred_taken), 128'(0));
`endif
    end
    @(posedge clk);
    if (!rst) begin
      m_inflight = 1'b0;
      m_redirect = 1'b0;
      foreach (m_ctr[i]) m_ctr[i] = 1;
    end else if (mr) begin
      acc = op.valid && op.is_branch && !m_redirect;
      nr  = 1'b0;
      if (m_inflight && !m_redirect) begin
        r = model(m_op);
        if (r.bv || r.lv || r.pv) exp_q.push_back(r);
        nr  = r.pv;
        t   = cond_true(m_op.cc, m_op.z, m_op.n, m_op.c, m_op.v);
        idx = pidx(m_op.base);
        m_ctr[idx] = t ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                       : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
      end
      m_redirect = nr;
      m_inflight = acc;
      m_op       = op;
    end
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(idle_op(), 1'b1, 1'b1, '0);
  endtask

  // Monitor: compare any presented result against the oldest expectation;
  // consume it only on a cycle where mem_ready lets it go.
  initial begin
    resp_t r;
    logic  any;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        any = bus.branch_valid | bus.link_valid | bus.next_pc_valid | bus.flush_pipeline;
        if (!any) begin
          check("idle_outputs", 128'({bus.next_link_reg, bus.next_pc, bus.user_data_out}), 128'(0));
        end else if (exp_q.size() == 0) begin
          check("unexpected_pulse",
                128'({bus.branch_valid, bus.link_valid, bus.next_pc_valid, bus.flush_pipeline}),
                128'(0));
        end else begin
          r = exp_q[0];
          if (mem_ready) begin
            check("resp", 128'({bus.branch_valid, bus.link_valid, bus.next_link_reg,
                                bus.next_pc_valid, bus.flush_pipeline, bus.next_pc,
                                bus.user_data_out}),
                  128'({r.bv, r.lv, r.lreg, r.pv, r.pv, r.pc, r.user}));
            void'(exp_q.pop_front());
          end else begin
            check("resp_held", 128'({bus.branch_valid, bus.link_valid, bus.next_link_reg,
                                     bus.next_pc_valid, bus.flush_pipeline, bus.next_pc,
                                     bus.user_data_out}),
                  128'({r.bv, r.lv, r.lreg, r.pv, r.pv, r.pc, r.user}));
          end
        end
      end
    end
  end

  initial begin
    op_t o;
    foreach (m_ctr[i]) m_ctr[i] = 1;
    for (int i = 0; i < 3; i++) step(idle_op(), 1'b1, 1'b0, '0);
    mon_en = 1'b1;
    check("reset_outputs", 128'({bus.branch_valid, bus.link_valid, bus.next_link_reg,
                                 bus.next_pc_valid, bus.flush_pipeline, bus.next_pc,
                                 bus.user_data_out}), 128'(0));
    idles(2);

    // AL relative: base 0x100, lit 10 -> 0x10C
    step(mk(4'hE, 1'b0, 1'b0, 32'h100, 32'h0, 32'd10, 4'h0), 1'b1, 1'b1, '0);
    idles(3);

    // Condition sampling: EQ z=0, GE n=v=1, LT n=1 v=0, NV, HI, LE
    step(mk(4'h0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h8, 4'b0000), 1'b1, 1'b1, '0); idles(3);
    step(mk(4'hA, 1'b0, 1'b0, 32'h300, 32'h0, 32'h8, 4'b0101), 1'b1, 1'b1, '0); idles(3);
    step(mk(4'hB, 1'b0, 1'b0, 32'h400, 32'h0, 32'h8, 4'b0100), 1'b1, 1'b1, '0); idles(3);
    step(mk(4'hF, 1'b0, 1'b1, 32'h500, 32'h0, 32'h8, 4'b1111), 1'b1, 1'b1, '0); idles(3);
    step(mk(4'h8, 1'b0, 1'b0, 32'h600, 32'h0, 32'h8, 4'b1010), 1'b1, 1'b1, '0); idles(3);
    step(mk(4'hD, 1'b0, 1'b0, 32'h700, 32'h0, 32'h8, 4'b0001), 1'b1, 1'b1, '0); idles(3);

    // Wrap: base FFFF_FFFE, lit 4 -> 0000_0004
    step(mk(4'hE, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h4, 4'h0), 1'b1, 1'b1, '0); idles(3);

    // AL absolute with link: rn 0x2000, base 0x40 -> link 0x42
    step(mk(4'hE, 1'b1, 1'b1, 32'h40, 32'h2000, 32'h0, 4'h0), 1'b1, 1'b1, '0); idles(3);

    // Stall in S1, stall with outputs shown, op offered during the flush cycle
    step(mk(4'hE, 1'b0, 1'b1, 32'h800, 32'h0, 32'h20, 4'h0), 1'b1, 1'b1, '0);
    step(idle_op(), 1'b0, 1'b1, '0);
    step(idle_op(), 1'b0, 1'b1, '0);
    step(idle_op(), 1'b1, 1'b1, '0);
    o = mk(4'hE, 1'b0, 1'b0, 32'h900, 32'h0, 32'h2, 4'h0);
    for (int i = 0; i < 3; i++) step(o, 1'b0, 1'b1, '0);
    step(o, 1'b1, 1'b1, '0);
    idles(3);

    // Back-to-back: second op accepted while first redirects is squashed
    step(mk(4'hE, 1'b0, 1'b0, 32'hA00, 32'h0, 32'h6, 4'h0), 1'b1, 1'b1, '0);
    step(mk(4'hE, 1'b0, 1'b0, 32'hB00, 32'h0, 32'h6, 4'h0), 1'b1, 1'b1, '0);
    idles(3);
    step(mk(4'h1, 1'b0, 1'b0, 32'hC00, 32'h0, 32'h6, 4'h8), 1'b1, 1'b1, '0);
    step(mk(4'h0, 1'b0, 1'b0, 32'hC02, 32'h0, 32'h6, 4'h0), 1'b1, 1'b1, '0);
    step(mk(4'hE, 1'b1, 1'b1, 32'hC04, 32'h1234, 32'h0, 4'h0), 1'b1, 1'b1, '0);
    idles(3);

    // Reset the cycle after accept: nothing emitted, outputs zero
    step(mk(4'hE, 1'b0, 1'b1, 32'hD00, 32'h0, 32'h6, 4'h0), 1'b1, 1'b1, '0);
    step(idle_op(), 1'b1, 1'b0, '0);
    check("midreset_outputs", 128'({bus.branch_valid, bus.link_valid, bus.next_link_reg,
                                    bus.next_pc_valid, bus.flush_pipeline, bus.next_pc,
                                    bus.user_data_out}), 128'(0));
    idles(3);

`ifdef BRANCH_PRED_EN
    // Same PC taken three times: only the first resolve redirects
    for (int k = 0; k < 3; k++) begin
      o = mk(4'hE, 1'b0, 1'b0, 32'h80, 32'h0, 32'h10, 4'h0);
      o.pred = (m_ctr[pidx(32'h80)] >= 2);
      step(o, 1'b1, 1'b1, 32'h80);
      for (int i = 0; i < 3; i++) step(idle_op(), 1'b1, 1'b1, 32'h80);
    end
    check("pred_after_train", 128'(fetch_pred_taken), 128'(1));
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      o.valid     = ($urandom_range(9) < 7);
      o.is_branch = ($urandom_range(9) < 9);
      o.cc        = 4'($urandom_range(15));
      o.link      = 1'($urandom);
      o.abs       = 1'($urandom);
      o.z = 1'($urandom); o.n = 1'($urandom); o.c = 1'($urandom); o.v = 1'($urandom);
      o.base      = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : 32'($urandom);
      o.rn        = 32'($urandom);
      o.lit       = 32'($urandom);
      o.pred      = 1'($urandom);
      o.user      = 1'($urandom);
      step(o, ($urandom_range(9) < 8), 1'b1, 32'($urandom_range(63)) << 1);
    end
    idles(6);
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
